// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute stage: FSM states, MD write-back
// selects, function-unit opcodes and a signed-overflow helper.
package exec_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } exec_state_e;

   localparam logic [1:0] MD_ALU = 2'd0;
   localparam logic [1:0] MD_MEM = 2'd1;
   localparam logic [1:0] MD_SLT = 2'd2;

   localparam logic [3:0] FS_MOVA = 4'h0;
   localparam logic [3:0] FS_INC  = 4'h1;
   localparam logic [3:0] FS_ADD  = 4'h2;
   localparam logic [3:0] FS_SUB  = 4'h5;
   localparam logic [3:0] FS_DEC  = 4'h6;
   localparam logic [3:0] FS_AND  = 4'h8;
   localparam logic [3:0] FS_OR   = 4'h9;
   localparam logic [3:0] FS_XOR  = 4'hA;
   localparam logic [3:0] FS_NOT  = 4'hB;
   localparam logic [3:0] FS_MOVB = 4'hC;
   localparam logic [3:0] FS_SRL  = 4'hD;
   localparam logic [3:0] FS_SLL  = 4'hE;

   // Two's-complement overflow of s = a + b, judged from the sign bits alone.
   function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                         input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/function_unit.sv
// Combinational ALU/shifter: result F plus negative (N) and signed overflow (V)
// flags; V is only meaningful for the arithmetic opcodes and is 0 otherwise.
module function_unit
   import exec_pkg::*;
#(
   parameter int DATA_BITS = 32,
   parameter int SH_WIDTH  = 5
) (
   input  logic [DATA_BITS-1:0] i_a,
   input  logic [DATA_BITS-1:0] i_b,
   input  logic [3:0]           i_fs,
   input  logic [SH_WIDTH-1:0]  i_sh,
   output logic [DATA_BITS-1:0] o_f,
   output logic                 o_n,
   output logic                 o_v
);

   localparam int                   MSB   = DATA_BITS - 1;
   localparam logic [DATA_BITS-1:0] L_ONE = DATA_BITS'(1);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves it unassigned, which would otherwise infer a latch.
      o_f = '0;
      o_v = 1'b0;
      case (i_fs)
         FS_MOVA: o_f = i_a;
         FS_INC: begin
            o_f = i_a + L_ONE;
            o_v = add_overflow(i_a[MSB], 1'b0, o_f[MSB]);
         end
         FS_ADD: begin
            o_f = i_a + i_b;
            o_v = add_overflow(i_a[MSB], i_b[MSB], o_f[MSB]);
         end
         FS_SUB: begin
            o_f = i_a - i_b;
            o_v = add_overflow(i_a[MSB], ~i_b[MSB], o_f[MSB]);
         end
         FS_DEC: begin
            o_f = i_a - L_ONE;
            o_v = add_overflow(i_a[MSB], 1'b1, o_f[MSB]);
         end
         FS_AND:  o_f = i_a & i_b;
         FS_OR:   o_f = i_a | i_b;
         FS_XOR:  o_f = i_a ^ i_b;
         FS_NOT:  o_f = ~i_a;
         FS_MOVB: o_f = i_b;
         FS_SRL:  o_f = i_b >> i_sh;
         FS_SLL:  o_f = i_b << i_sh;
         default: o_f = '0;
      endcase
   end

   assign o_n = o_f[MSB];

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier keeping only the low DATA_BITS of the product.
// o_done is high during the cycle whose clock edge performs the last step.
module seq_multiplier #(
   parameter int DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [DATA_BITS-1:0] i_a,
   input  logic [DATA_BITS-1:0] i_b,
   output logic                 o_done,
   output logic [DATA_BITS-1:0] o_product
);

   localparam int             CNT_W  = $clog2(DATA_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

   logic [DATA_BITS-1:0] r_mcand;
   logic [DATA_BITS-1:0] r_mplier;
   logic [DATA_BITS-1:0] r_acc;
   logic [CNT_W-1:0]     r_count;
   logic                 r_run;

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_run    <= 1'b0;
      end else if (i_abort) begin
         r_run <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_count  <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CNT_W'(1);
         if (r_count == LAST) begin
            r_run <= 1'b0;
         end
      end
   end

   assign o_done    = r_run && (r_count == LAST);
   assign o_product = r_acc;

endmodule

// File: rtl/execute_pipe.sv
// Execute stage with valid/ready handshakes, one-cycle ALU path and optional
// multi-cycle multiplier (compiled in when EXECUTE_PIPE_MUL_EN is defined).
module execute_pipe
   import exec_pkg::*;
#(
   parameter int DATA_BITS      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int PC_WIDTH       = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      RW,
   input  logic [REG_ADDR_WIDTH-1:0] DA,
   input  logic [1:0]                MD,
   input  logic [3:0]                FS,
   input  logic [REG_ADDR_WIDTH-1:0] SH,
   input  logic                      MUL,
   input  logic [DATA_BITS-1:0]      BUSA,
   input  logic [DATA_BITS-1:0]      BUSB,
   input  logic [PC_WIDTH-1:0]       pc_min_two,
   input  logic [DATA_BITS-1:0]      DData,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      RW_WB,
   output logic [REG_ADDR_WIDTH-1:0] DA_WB,
   output logic [1:0]                MD_WB,
   output logic [DATA_BITS-1:0]      result,
   output logic                      determinate,
   output logic [DATA_BITS-1:0]      DData_next,
   output logic [DATA_BITS-1:0]      BrA,
   output logic [DATA_BITS-1:0]      forward_data,
   output logic                      busy
);

   exec_state_e               r_state;
   logic                      r_out_valid;
   logic                      r_rw_wb;
   logic [REG_ADDR_WIDTH-1:0] r_da_wb;
   logic [1:0]                r_md_wb;
   logic [DATA_BITS-1:0]      r_result;
   logic                      r_determinate;
   logic [DATA_BITS-1:0]      r_ddata_next;

   logic                      w_accept;
   logic                      w_is_mul;
   logic                      w_det_next;
   logic [DATA_BITS-1:0]      w_fu_f;
   logic                      w_fu_n;
   logic                      w_fu_v;
   logic [PC_WIDTH-1:0]       w_busb_pc;

   function_unit #(
      .DATA_BITS (DATA_BITS),
      .SH_WIDTH  (REG_ADDR_WIDTH)
   ) u_fu (
      .i_a  (BUSA),
      .i_b  (BUSB),
      .i_fs (FS),
      .i_sh (SH),
      .o_f  (w_fu_f),
      .o_n  (w_fu_n),
      .o_v  (w_fu_v)
   );

   assign w_det_next = w_fu_n ^ w_fu_v;
   assign in_ready   = rst_n && (r_state == IDLE) && !flush &&
                       (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;

`ifdef EXECUTE_PIPE_MUL_EN
   logic                      w_mul_done;
   logic [DATA_BITS-1:0]      w_mul_product;
   logic                      r_mul_rw;
   logic [REG_ADDR_WIDTH-1:0] r_mul_da;
   logic [1:0]                r_mul_md;
   logic [DATA_BITS-1:0]      r_mul_ddata;

   assign w_is_mul = MUL;
   assign busy     = (r_state != IDLE);

   seq_multiplier #(
      .DATA_BITS (DATA_BITS)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_accept && MUL),
      .i_abort   (flush),
      .i_a       (BUSA),
      .i_b       (BUSB),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // Sideband fields ride alongside the multiply until it retires.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mul_rw    <= 1'b0;
         r_mul_da    <= '0;
         r_mul_md    <= '0;
         r_mul_ddata <= '0;
      end else if (w_accept && MUL) begin
         r_mul_rw    <= RW;
         r_mul_da    <= DA;
         r_mul_md    <= MD;
         r_mul_ddata <= DData;
      end
   end
`else
   logic w_unused_mul;

   assign w_is_mul     = 1'b0;
   assign busy         = 1'b0;
   assign w_unused_mul = MUL;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_out_valid   <= 1'b0;
         r_rw_wb       <= 1'b0;
         r_da_wb       <= '0;
         r_md_wb       <= '0;
         r_result      <= '0;
         r_determinate <= 1'b0;
         r_ddata_next  <= '0;
      end else if (flush) begin
         // Kill only the valid/write-enable; payload keeps its last value.
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_rw_wb     <= 1'b0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_rw_wb     <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_state <= MUL_RUN;
                  end else begin
                     r_out_valid   <= 1'b1;
                     r_rw_wb       <= RW;
                     r_da_wb       <= DA;
                     r_md_wb       <= MD;
                     r_result      <= w_fu_f;
                     r_determinate <= w_det_next;
                     r_ddata_next  <= DData;
                  end
               end
            end
`ifdef EXECUTE_PIPE_MUL_EN
            MUL_RUN: begin
               if (w_mul_done) begin
                  r_state <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               r_state       <= IDLE;
               r_out_valid   <= 1'b1;
               r_rw_wb       <= r_mul_rw;
               r_da_wb       <= r_mul_da;
               r_md_wb       <= r_mul_md;
               r_result      <= w_mul_product;
               r_determinate <= 1'b0;
               r_ddata_next  <= r_mul_ddata;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid   = r_out_valid;
   assign RW_WB       = r_rw_wb;
   assign DA_WB       = r_da_wb;
   assign MD_WB       = r_md_wb;
   assign result      = r_result;
   assign determinate = r_determinate;
   assign DData_next  = r_ddata_next;

   generate
      if (PC_WIDTH > DATA_BITS) begin : g_busb_zext
         assign w_busb_pc = {{(PC_WIDTH - DATA_BITS){1'b0}}, BUSB};
      end else begin : g_busb_trunc
         assign w_busb_pc = BUSB[PC_WIDTH-1:0];
      end
   endgenerate

   assign BrA = pc_min_two + w_busb_pc;

   // A multiply in MD_ALU has no value yet; consumers stall on busy instead.
   always_comb begin
      forward_data = '0;
      case (MD)
         MD_ALU:  forward_data = w_is_mul ? '0 : w_fu_f;
         MD_MEM:  forward_data = DData;
         MD_SLT:  forward_data = {{(DATA_BITS - 1){1'b0}}, w_det_next};
         default: forward_data = '0;
      endcase
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed self-checking bench for execute_pipe; multiplier expectations are
// selected by EXECUTE_PIPE_MUL_EN to match the build under test.
module tb_execute_pipe;
   import exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        RW;
   logic [4:0]  DA;
   logic [1:0]  MD;
   logic [3:0]  FS;
   logic [4:0]  SH;
   logic        MUL;
   logic [31:0] BUSA;
   logic [31:0] BUSB;
   logic [31:0] pc_min_two;
   logic [31:0] DData;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        RW_WB;
   logic [4:0]  DA_WB;
   logic [1:0]  MD_WB;
   logic [31:0] result;
   logic        determinate;
   logic [31:0] DData_next;
   logic [31:0] BrA;
   logic [31:0] forward_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   execute_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .RW           (RW),
      .DA           (DA),
      .MD           (MD),
      .FS           (FS),
      .SH           (SH),
      .MUL          (MUL),
      .BUSA         (BUSA),
      .BUSB         (BUSB),
      .pc_min_two   (pc_min_two),
      .DData        (DData),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .RW_WB        (RW_WB),
      .DA_WB        (DA_WB),
      .MD_WB        (MD_WB),
      .result       (result),
      .determinate  (determinate),
      .DData_next   (DData_next),
      .BrA          (BrA),
      .forward_data (forward_data),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic [4:0] da, input logic [1:0] md,
                        input logic [3:0] fs, input logic [4:0] sh, input logic mul,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] dd);
      in_valid = 1'b1;
      RW = rw; DA = da; MD = md; FS = fs; SH = sh; MUL = mul;
      BUSA = a; BUSB = b; DData = dd;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      MUL      = 1'b0;
   endtask

   // Count cycles with no output for a while after an aborted operation.
   task automatic expect_quiet(input string tag);
      int ov_cnt;
      ov_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
      end
      check(tag, ov_cnt, 0);
   endtask

`ifdef EXECUTE_PIPE_MUL_EN
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int busy_cnt, rdy_cnt, ov_cnt;
      busy_cnt = 0; rdy_cnt = 0; ov_cnt = 0;
      tick();
      drive(1'b1, 5'd4, MD_ALU, FS_ADD, 5'd0, 1'b1, a, b, 32'h33);
      @(negedge clk);
      check({tag, "_fwd_zero"}, forward_data, 0);
      check({tag, "_busy_pre"}, busy, 0);
      tick();
      idle_in();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cnt++;
         if (in_ready) rdy_cnt++;
         if (out_valid) ov_cnt++;
      end
      check({tag, "_busy_cycles"}, busy_cnt, 33);
      check({tag, "_ready_while_busy"}, rdy_cnt, 0);
      check({tag, "_valid_while_busy"}, ov_cnt, 0);
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_result"}, result, exp);
      check({tag, "_det"}, determinate, 0);
      check({tag, "_da"}, DA_WB, 4);
      check({tag, "_rw"}, RW_WB, 1);
      check({tag, "_ddata"}, DData_next, 32'h33);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; pc_min_two = '0;
      in_valid = 1'b0; RW = 1'b0; DA = '0; MD = '0; FS = '0; SH = '0; MUL = 1'b0;
      BUSA = '0; BUSB = '0; DData = '0;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_in_ready_low", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_rw_wb", RW_WB, 0);
      check("rst_det", determinate, 0);
      check("rst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // ALU add: latency 1, payload copied
      tick();
      pc_min_two = 32'd100;
      drive(1'b1, 5'd3, MD_ALU, FS_ADD, 5'd0, 1'b0, 32'd5, 32'd7, 32'h55);
      @(negedge clk);
      check("add_fwd", forward_data, 12);
      check("add_bra", BrA, 107);
      tick();
      idle_in();
      @(negedge clk);
      check("add_valid", out_valid, 1);
      check("add_result", result, 12);
      check("add_rw", RW_WB, 1);
      check("add_da", DA_WB, 3);
      check("add_ddata", DData_next, 32'h55);
      check("add_det", determinate, 0);
      tick();
      @(negedge clk);
      check("consume_valid", out_valid, 0);
      check("consume_rw", RW_WB, 0);
      check("consume_result_hold", result, 12);

      // Branch target wraps at PC_WIDTH
      pc_min_two = 32'hFFFF_FFF0;
      BUSB = 32'h20;
      #1;
      check("bra_wrap", BrA, 32'h10);

      // Set-less-than and MD selects, issued back to back
      tick();
      drive(1'b0, 5'd5, MD_SLT, FS_SUB, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
      @(negedge clk);
      check("slt_neg_fwd", forward_data, 1);
      tick();
      drive(1'b1, 5'd6, MD_SLT, FS_SUB, 5'd0, 1'b0, 32'h8000_0000, 32'd1, 32'd0);
      @(negedge clk);
      check("slt_neg_det", determinate, 1);
      check("slt_neg_result", result, 32'hFFFF_FFFE);
      check("slt_neg_md", MD_WB, 2);
      check("slt_ovf_fwd", forward_data, 1);
      tick();
      drive(1'b0, 5'd7, MD_SLT, FS_SUB, 5'd0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
      @(negedge clk);
      check("slt_ovf_det", determinate, 1);
      check("slt_ovf_result", result, 32'h7FFF_FFFF);
      check("slt_ovf_da", DA_WB, 6);
      check("slt_pos_fwd", forward_data, 0);
      tick();
      drive(1'b1, 5'd8, MD_MEM, FS_SLL, 5'd4, 1'b0, 32'd0, 32'd3, 32'hCAFE);
      @(negedge clk);
      check("slt_pos_det", determinate, 0);
      check("slt_pos_result", result, 2);
      check("mem_fwd", forward_data, 32'hCAFE);
      tick();
      drive(1'b0, 5'd9, 2'd3, FS_ADD, 5'd0, 1'b0, 32'd1, 32'd1, 32'd0);
      @(negedge clk);
      check("sll_result", result, 32'h30);
      check("mem_ddata", DData_next, 32'hCAFE);
      check("mem_md", MD_WB, 1);
      check("md3_fwd", forward_data, 0);
      tick();
      idle_in();
      @(negedge clk);
      check("md3_result", result, 2);
      check("md3_md", MD_WB, 3);
      tick();

      // Backpressure: hold for 3 cycles, then consume and accept together
      out_ready = 1'b0;
      drive(1'b1, 5'd7, MD_ALU, FS_AND, 5'd0, 1'b0, 32'hF0F0, 32'hFF00, 32'h11);
      tick();
      drive(1'b1, 5'd9, MD_ALU, FS_OR, 5'd0, 1'b0, 32'h0F, 32'hF0, 32'h22);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_result", result, 32'hF000);
         check("stall_da", DA_WB, 7);
         check("stall_ddata", DData_next, 32'h11);
         check("stall_in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      tick();
      idle_in();
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", result, 32'hFF);
      check("b2b_da", DA_WB, 9);
      check("b2b_ddata", DData_next, 32'h22);
      tick();
      @(negedge clk);
      check("b2b_drain", out_valid, 0);

`ifdef EXECUTE_PIPE_MUL_EN
      // Multiply: 33 busy cycles, low product bits
      run_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
      run_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      run_mul("mul_shift", 32'h1234_5678, 32'h10, 32'h2345_6780);

      // Flush at cycle 10 of a multiply; a competing accept is refused
      tick();
      drive(1'b1, 5'd12, MD_ALU, FS_ADD, 5'd0, 1'b1, 32'd3, 32'd5, 32'd0);
      tick();
      idle_in();
      repeat (9) tick();
      flush = 1'b1;
      drive(1'b1, 5'd1, MD_ALU, FS_ADD, 5'd0, 1'b0, 32'd1, 32'd1, 32'd0);
      @(negedge clk);
      check("flush_busy_before", busy, 1);
      check("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      idle_in();
      @(negedge clk);
      check("flush_busy", busy, 0);
      check("flush_valid", out_valid, 0);
      check("flush_rw", RW_WB, 0);
      check("flush_in_ready_after", in_ready, 1);
      check("flush_result_hold", result, 32'h2345_6780);
      check("flush_da_hold", DA_WB, 4);
      expect_quiet("flush_no_late_result");
`else
      // Multiplier absent: MUL takes the single-cycle path
      tick();
      drive(1'b1, 5'd4, MD_ALU, FS_ADD, 5'd0, 1'b1, 32'd6, 32'd7, 32'h33);
      @(negedge clk);
      check("nomul_fwd", forward_data, 13);
      check("nomul_busy", busy, 0);
      tick();
      idle_in();
      @(negedge clk);
      check("nomul_valid", out_valid, 1);
      check("nomul_result", result, 13);
      check("nomul_busy_after", busy, 0);

      // Flush a held result; payload stays, valid and write-enable drop
      tick();
      out_ready = 1'b0;
      drive(1'b1, 5'd12, MD_ALU, FS_ADD, 5'd0, 1'b0, 32'd20, 32'd22, 32'd0);
      tick();
      idle_in();
      @(negedge clk);
      check("flush_pre_valid", out_valid, 1);
      tick();
      flush = 1'b1;
      drive(1'b1, 5'd1, MD_ALU, FS_ADD, 5'd0, 1'b0, 32'd1, 32'd1, 32'd0);
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      idle_in();
      @(negedge clk);
      check("flush_valid", out_valid, 0);
      check("flush_rw", RW_WB, 0);
      check("flush_result_hold", result, 42);
      check("flush_da_hold", DA_WB, 12);
      expect_quiet("flush_no_late_result");
`endif

      // Reset mid-operation
      tick();
      drive(1'b1, 5'd2, MD_MEM, FS_ADD, 5'd0, 1'b1, 32'd9, 32'd9, 32'h77);
      tick();
      idle_in();
      repeat (5) tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 0);
      tick();
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_da", DA_WB, 0);
      check("midrst_md", MD_WB, 0);
      check("midrst_ddata", DData_next, 0);
      check("midrst_rw", RW_WB, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready_after", in_ready, 1);
      expect_quiet("midrst_no_late_result");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
